// File: rtl/temp_bcd_conv.sv
// temp_bcd_conv: ADC code * SCALE saturated at 9999 and converted to packed BCD; ports clk, rst, sample_valid, sample[7:0] in; busy, bcd_valid, bcd[15:0], over out
module temp_bcd_conv #(
  parameter logic [7:0] SCALE = 8'd100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_valid,
  input  logic [7:0]  sample,
  output logic        busy,
  output logic        bcd_valid,
  output logic [15:0] bcd,
  output logic        over
);
  typedef enum logic [2:0] {IDLE, MUL, SAT, DAB, DONE} state_t;
  state_t state, nxt;
  logic [7:0]  smp, pend, start_smp;
  logic        pend_v, ovf, start, stash;
  logic [15:0] acc;
  logic [3:0]  cnt;
  logic [29:0] dd, dd_adj;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = sample_valid ? MUL : IDLE;
      MUL:     nxt = cnt == 4'd7 ? SAT : MUL;
      SAT:     nxt = DAB;
      DAB:     nxt = cnt == 4'd13 ? DONE : DAB;
      DONE:    nxt = (pend_v || sample_valid) ? MUL : IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    start     = (state == IDLE && sample_valid) || (state == DONE && (pend_v || sample_valid));
    start_smp = sample_valid ? sample : pend;
    stash     = sample_valid && state != IDLE && state != DONE;
  end
  always_comb begin
    dd_adj = dd;
    for (int k = 0; k < 4; k++)
      dd_adj[14+4*k +: 4] = dd[14+4*k +: 4] >= 4'd5 ? dd[14+4*k +: 4] + 4'd3 : dd[14+4*k +: 4];
  end
  always_ff @(posedge clk)
    if (rst) begin
      smp       <= '0;
      pend      <= '0;
      pend_v    <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      dd        <= '0;
      ovf       <= 1'b0;
      busy      <= 1'b0;
      bcd_valid <= 1'b0;
      bcd       <= '0;
      over      <= 1'b0;
    end else begin
      busy      <= nxt != IDLE;
      bcd_valid <= state == DONE;
      if (stash) begin
        pend   <= sample;
        pend_v <= 1'b1;
      end else if (state == DONE) pend_v <= 1'b0;
      case (state)
        MUL: begin
          acc <= acc + (smp[cnt[2:0]] ? 16'(SCALE) << cnt[2:0] : 16'd0);
          cnt <= cnt + 4'd1;
        end
        SAT: begin
          ovf <= acc > 16'd9999;
          dd  <= {16'h0, acc > 16'd9999 ? 14'd9999 : acc[13:0]};
          cnt <= '0;
        end
        DAB: begin
          dd  <= dd_adj << 1;
          cnt <= cnt + 4'd1;
        end
        DONE: begin
          bcd  <= dd[29:14];
          over <= ovf;
        end
        default: ;
      endcase
      if (start) begin
        smp <= start_smp;
        acc <= '0;
        cnt <= '0;
      end
    end
endmodule

// File: tb/tb_temp_bcd_conv.sv
// tb_temp_bcd_conv: randomized self-checking bench for temp_bcd_conv at SCALE 100, 99 and 196
module tb_temp_bcd_conv;
  logic        clk = 1'b0, rst = 1'b1;
  logic        sv[3];
  logic [7:0]  s[3];
  logic        bz[3], bv[3], ov[3];
  logic [15:0] bc[3];
  int          total = 0, fails = 0;
  always #5 clk = ~clk;
  temp_bcd_conv #(.SCALE(8'd100)) u100 (.clk(clk), .rst(rst), .sample_valid(sv[0]), .sample(s[0]),
    .busy(bz[0]), .bcd_valid(bv[0]), .bcd(bc[0]), .over(ov[0]));
  temp_bcd_conv #(.SCALE(8'd99)) u99 (.clk(clk), .rst(rst), .sample_valid(sv[1]), .sample(s[1]),
    .busy(bz[1]), .bcd_valid(bv[1]), .bcd(bc[1]), .over(ov[1]));
  temp_bcd_conv #(.SCALE(8'd196)) u196 (.clk(clk), .rst(rst), .sample_valid(sv[2]), .sample(s[2]),
    .busy(bz[2]), .bcd_valid(bv[2]), .bcd(bc[2]), .over(ov[2]));
  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [16:0] model(input int scale, input int code);
    int v;
    v = scale * code;
    return {v > 9999, 4'((v > 9999 ? 9999 : v) / 1000 % 10), 4'((v > 9999 ? 9999 : v) / 100 % 10),
            4'((v > 9999 ? 9999 : v) / 10 % 10), 4'((v > 9999 ? 9999 : v) % 10)};
  endfunction
  function automatic bit digits_ok(input logic [15:0] b);
    return b[15:12] <= 9 && b[11:8] <= 9 && b[7:4] <= 9 && b[3:0] <= 9;
  endfunction
  task automatic run(input int d, input logic [7:0] code, input logic [16:0] exp, input string tag);
    int n;
    bit busy_ok;
    n = 0;
    busy_ok = 1;
    @(negedge clk);
    sv[d] = 1'b1;
    s[d] = code;
    @(posedge clk);
    #1 sv[d] = 1'b0;
    while (n < 40) begin
      if (!bz[d]) busy_ok = 0;
      @(posedge clk);
      #1 n++;
      if (bv[d]) break;
    end
    check({tag, "_lat"}, n, 24);
    check({tag, "_busy"}, int'(busy_ok), 1);
    check({tag, "_bcd"}, int'(bc[d]), int'(exp[15:0]));
    check({tag, "_over"}, int'(ov[d]), int'(exp[16]));
    check({tag, "_digits"}, int'(digits_ok(bc[d])), 1);
  endtask
  initial begin
    int pulses, at[$];
    logic [15:0] val[$];
    int codes[256];
    for (int i = 0; i < 3; i++) begin
      sv[i] = 1'b0;
      s[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_busy", int'(bz[0]), 0);
    check("rst_valid", int'(bv[0]), 0);
    check("rst_bcd", int'(bc[0]), 0);
    check("rst_over", int'(ov[0]), 0);
    run(0, 8'd25, 17'h02500, "t1_25");
    run(0, 8'd255, 17'h19999, "t2_255");
    run(0, 8'd0, 17'h00000, "t2_0");
    run(1, 8'd101, 17'h09999, "t3_101");
    run(1, 8'd102, 17'h19999, "t3_102");
    run(2, 8'd37, 17'h07252, "t6_37");
    for (int i = 0; i < 30; i++) begin
      automatic logic [7:0] c = 8'($urandom_range(0, 255));
      run(0, c, model(100, c), "rnd100");
    end
    for (int i = 0; i < 20; i++) begin
      automatic logic [7:0] c = 8'($urandom_range(90, 120));
      run(1, c, model(99, c), "rnd99");
    end
    @(negedge clk);
    sv[0] = 1'b1;
    s[0] = 8'd10;
    @(posedge clk);
    #1 sv[0] = 1'b0;
    for (int e = 1; e <= 60; e++) begin
      if (e == 5 || e == 10) begin
        sv[0] = 1'b1;
        s[0] = e == 5 ? 8'd20 : 8'd30;
      end
      @(posedge clk);
      #1 sv[0] = 1'b0;
      if (bv[0]) begin
        at.push_back(e);
        val.push_back(bc[0]);
      end
    end
    check("t4_pulses", at.size(), 2);
    if (at.size() == 2) begin
      check("t4_edge0", at[0], 24);
      check("t4_bcd0", int'(val[0]), 16'h1000);
      check("t4_edge1", at[1], 48);
      check("t4_bcd1", int'(val[1]), 16'h3000);
    end
    check("t4_idle", int'(bz[0]), 0);
    @(negedge clk);
    sv[0] = 1'b1;
    s[0] = 8'd50;
    @(posedge clk);
    #1 sv[0] = 1'b0;
    repeat (11) @(posedge clk);
    #1 rst = 1'b1;
    sv[0] = 1'b1;
    s[0] = 8'd99;
    @(posedge clk);
    #1 rst = 1'b0;
    sv[0] = 1'b0;
    check("t5_busy", int'(bz[0]), 0);
    check("t5_bcd", int'(bc[0]), 0);
    check("t5_over", int'(ov[0]), 0);
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (bv[0] || bz[0]) pulses++;
    end
    check("t5_quiet", pulses, 0);
    for (int i = 0; i < 256; i++) codes[i] = i;
    for (int i = 255; i > 0; i--) begin
      automatic int j = int'($urandom_range(0, i));
      automatic int t = codes[i];
      codes[i] = codes[j];
      codes[j] = t;
    end
    for (int i = 0; i < 256; i++) run(2, 8'(codes[i]), model(196, codes[i]), "sweep196");
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
